// File: rtl/power_of_3_if.sv
// rtl/power_of_3_if.sv - Value-under-test and result signals of the power-of-three detector.
interface power_of_3_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] num;
  logic             ispow3;
  logic [4:0]       pow_exp;

  modport master (output num, input ispow3, input pow_exp);
  modport slave  (input num, output ispow3, output pow_exp);
endinterface

// File: rtl/power_of_3.sv
// rtl/power_of_3.sv - Registered detector flagging num == 3^k and reporting k.
module power_of_3 #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  power_of_3_if.slave  bus
);

  // Constants are built in 64 bits so 3^k is never truncated to WIDTH.
  function automatic logic [63:0] pow3(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd3;
    end
    return p;
  endfunction

  function automatic int kmax_of(input int w);
    logic [63:0] max_val;
    logic [63:0] p;
    int          k;
    max_val = (64'd1 << w) - 64'd1;
    p       = 64'd1;
    k       = 0;
    for (int i = 0; i < 40; i++) begin
      if (p * 64'd3 <= max_val) begin
        p = p * 64'd3;
        k = i + 1;
      end
    end
    return k;
  endfunction

  localparam int KMAX = kmax_of(WIDTH);

  logic [63:0] num_ext;
  logic [KMAX:0] match;
  logic          hit;
  logic [4:0]    exp_enc;
  logic          ispow3_q;
  logic [4:0]    pow_exp_q;

  assign num_ext = {{(64 - WIDTH){1'b0}}, bus.num};

  for (genvar k = 0; k <= KMAX; k++) begin : g_cmp
    localparam logic [63:0] POW = pow3(k);
    assign match[k] = (num_ext == POW);
  end

  // At most one constant can match, so OR-ing the indices is an exact one-hot encoder.
  always_comb begin
    exp_enc = 5'd0;
    for (int k = 0; k <= KMAX; k++) begin
      exp_enc = exp_enc | (match[k] ? 5'(k) : 5'd0);
    end
    hit = |match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ispow3_q  <= 1'b0;
      pow_exp_q <= 5'd0;
    end else begin
      ispow3_q  <= hit;
      pow_exp_q <= exp_enc;
    end
  end

  assign bus.ispow3  = ispow3_q;
  assign bus.pow_exp = pow_exp_q;

endmodule

// File: tb/tb_power_of_3.sv
// tb/tb_power_of_3.sv - Scoreboard bench for power_of_3 with a behavioural reference model.
module tb_power_of_3;

  typedef struct {
    bit          p;
    logic [4:0]  e;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  power_of_3_if #(.WIDTH(32)) bus ();

  power_of_3 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: walk the powers of three upward with plain multiplication.
  function automatic exp_t ref_model(input logic [31:0] v);
    exp_t        r;
    logic [63:0] p;
    r.p = 1'b0;
    r.e = 5'd0;
    r.v = v;
    p   = 64'd1;
    for (int k = 0; k < 40; k++) begin
      if (p == {32'd0, v}) begin
        r.p = 1'b1;
        r.e = 5'(k);
      end
      p = p * 64'd3;
    end
    return r;
  endfunction

  function automatic logic [31:0] pow3_wrapped(input int k);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < k; i++) p = p * 64'd3;
    return p[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic [31:0] v);
    @(negedge clk);
    bus.num = v;
    sb.push_back(ref_model(v));
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_cmp++;
      if (bus.ispow3 !== x.p || bus.pow_exp !== x.e) begin
        n_err++;
        $display("FAIL result num=%0d: got ispow3=%0b pow_exp=%0d expected ispow3=%0b pow_exp=%0d",
                 x.v, bus.ispow3, bus.pow_exp, x.p, x.e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] near [9];
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    bus.num = 32'd27;

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_ispow3", {31'd0, bus.ispow3}, 32'd0);
      check("reset_pow_exp", {27'd0, bus.pow_exp}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(ref_model(32'd27));

    for (int k = 0; k <= 20; k++) drive(pow3_wrapped(k));
    for (int k = 21; k <= 27; k++) drive(pow3_wrapped(k));

    near = '{32'd0, 32'd2, 32'd4, 32'd8, 32'd26, 32'd28, 32'd242, 32'd244, 32'hFFFF_FFFF};
    for (int i = 0; i < 9; i++) drive(near[i]);

    for (int i = 0; i < 10; i++) drive((i % 2 == 0) ? 32'd9 : 32'd10);

    for (int i = 0; i < 300; i++) begin
      int          sel;
      logic [31:0] p;
      sel = int'($urandom_range(0, 3));
      p   = pow3_wrapped(int'($urandom_range(0, 20)));
      case (sel)
        0:       drive(p);
        1:       drive(p + 32'd1);
        2:       drive(p - 32'd1);
        default: drive($urandom);
      endcase
    end

    drive(32'd81);
    @(posedge clk);
    #3;
    check("pre_async_ispow3", {31'd0, bus.ispow3}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_ispow3", {31'd0, bus.ispow3}, 32'd0);
    check("async_pow_exp", {27'd0, bus.pow_exp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(32'd3486784401);
    drive(32'd1);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
